// File: rtl/adc_ddr_capture.sv
// DDR ADC bus capture: pairs rise/fall halves into words, crosses dco -> sclk
// through a gray-pointer async FIFO, and presents them on a valid/ready stream.
module adc_ddr_capture #(
  parameter int LANE_W      = 8,
  parameter int DEPTH       = 8,
  parameter int INTERLEAVE  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     dco,
  input  logic [LANE_W-1:0]        data_in,
  input  logic                     en,
  output logic [2*LANE_W-1:0]      dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 2 * LANE_W;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [DW-1:0] map_word(input logic [DW-1:0] w);
    logic [DW-1:0] m;
    m = w;
    if (INTERLEAVE != 0) begin
      for (int i = 0; i < LANE_W; i++) begin
        m[2*i]   = w[i];
        m[2*i+1] = w[LANE_W+i];
      end
    end
    return m;
  endfunction

  // ---------------- dco domain ----------------
  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   rst_dco_n;

  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_dco_n = rst_sync[SYNC_STAGES-1];

  logic [SYNC_STAGES-1:0] en_sync;
  logic                   en_d;

  always_ff @(posedge dco or negedge rst_dco_n) begin
    if (!rst_dco_n) en_sync <= '0;
    else            en_sync <= {en_sync[SYNC_STAGES-2:0], en};
  end
  assign en_d = en_sync[SYNC_STAGES-1];

  logic [LANE_W-1:0] half_l, half_h;

  always_ff @(posedge dco or negedge rst_dco_n) begin
    if (!rst_dco_n) half_l <= '0;
    else            half_l <= data_in;
  end

  always_ff @(negedge dco or negedge rst_dco_n) begin
    if (!rst_dco_n) half_h <= '0;
    else            half_h <= data_in;
  end

  logic [PW-1:0] wr_ptr, wr_gray, wr_ptr_nxt;
  logic [PW-1:0] rd_gray;
  logic [PW-1:0] rd_sync [SYNC_STAGES];
  logic [PW-1:0] rd_gray_dco;
  logic          armed, drop, full, wr_en;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge dco or negedge rst_dco_n) begin
    if (!rst_dco_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rd_sync[i] <= '0;
    end else begin
      rd_sync[0] <= rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++) rd_sync[i] <= rd_sync[i-1];
    end
  end
  assign rd_gray_dco = rd_sync[SYNC_STAGES-1];

  assign full       = (wr_gray == {~rd_gray_dco[PW-1:PW-2], rd_gray_dco[PW-3:0]});
  // A write needs a full pair captured under enable and enable still present.
  assign wr_en      = armed & en_d;
  assign wr_ptr_nxt = wr_ptr + 1'b1;

  always_ff @(posedge dco or negedge rst_dco_n) begin
    if (!rst_dco_n) begin
      armed   <= 1'b0;
      drop    <= 1'b0;
      wr_ptr  <= '0;
      wr_gray <= '0;
    end else begin
      armed <= en_d;
      if (!en_d)              drop <= 1'b0;
      else if (wr_en && full) drop <= 1'b1;
      if (wr_en && !full) begin
        wr_ptr  <= wr_ptr_nxt;
        wr_gray <= bin2gray(wr_ptr_nxt);
      end
    end
  end

  always_ff @(posedge dco or negedge rst_dco_n) begin
    if (!rst_dco_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= {half_h, half_l};
    end
  end

  // ---------------- sclk domain ----------------
  logic [PW-1:0]          wr_sync [SYNC_STAGES];
  logic [PW-1:0]          wr_gray_s, wr_bin_s;
  logic [PW-1:0]          rd_ptr;
  logic [SYNC_STAGES-1:0] ovf_sync;
  logic                   empty, load;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wr_sync[i] <= '0;
      ovf_sync <= '0;
    end else begin
      wr_sync[0] <= wr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) wr_sync[i] <= wr_sync[i-1];
      ovf_sync <= {ovf_sync[SYNC_STAGES-2:0], drop};
    end
  end

  assign wr_gray_s = wr_sync[SYNC_STAGES-1];
  assign wr_bin_s  = gray2bin(wr_gray_s);
  assign empty     = (rd_gray == wr_gray_s);
  assign load      = !empty && (!dout_valid || dout_ready);
  assign level     = wr_bin_s - rd_ptr;
  assign overflow  = ovf_sync[SYNC_STAGES-1];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      rd_ptr     <= '0;
      rd_gray    <= '0;
    end else if (load) begin
      dout       <= map_word(mem[rd_ptr[AW-1:0]]);
      dout_valid <= 1'b1;
      rd_ptr     <= rd_ptr + 1'b1;
      rd_gray    <= bin2gray(rd_ptr + 1'b1);
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
